// File: rtl/mod_delay_reader_if.sv
// Stream bundle between the LFO/audio producers and the modulated delay line.
//
// Handshake: sampleValid_i and newValFlag_i are single-cycle strobes that
// qualify sample_i and wave_i in the cycle they are high. They have no
// backpressure. The producer may strobe sampleValid_i only while busy_o is
// low, which is the ready condition. A strobe while busy_o is high is dropped
// and latches drop_o. sampleValid_o is a single-cycle strobe qualifying
// sample_o. sample_o holds its value between strobes.
interface mod_delay_reader_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] sample_i;
  logic                     sampleValid_i;
  logic signed [13:0]       wave_i;
  logic                     newValFlag_i;
  logic signed [DATA_W-1:0] sample_o;
  logic                     sampleValid_o;
  logic                     busy_o;
  logic                     drop_o;

  modport master (
    output sample_i, sampleValid_i, wave_i, newValFlag_i,
    input  sample_o, sampleValid_o, busy_o, drop_o
  );

  modport slave (
    input  sample_i, sampleValid_i, wave_i, newValFlag_i,
    output sample_o, sampleValid_o, busy_o, drop_o
  );
endinterface

// File: rtl/mod_delay_reader.sv
// LFO-modulated fractional delay line. Incoming samples go into a circular
// RAM. Each pass reads two adjacent taps at (base + scaled LFO) delay and
// linearly interpolates between them. It feeds the chorus/flanger voice.
module mod_delay_reader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 11,
  parameter int FRAC_W     = 8,
  parameter int BASE_DELAY = 882,
  parameter int WAVE_SHIFT = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mod_delay_reader_if.slave  io,
  output logic [2:0]         dbg_state_o
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WAVE_W = 14;
  localparam int DW     = ADDR_W + FRAC_W + 2;   // signed fixed-point delay
  localparam int UW     = ADDR_W + FRAC_W;       // clamped delay, always positive
  localparam int PW     = DATA_W + FRAC_W + 2;   // interpolation product

  localparam logic signed [DW-1:0] BASE_FX = DW'(BASE_DELAY << FRAC_W);
  localparam logic signed [DW-1:0] MIN_FX  = DW'(1 << FRAC_W);
  localparam logic signed [DW-1:0] MAX_FX  = DW'((DEPTH - 2) << FRAC_W);

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_RDA    = 3'd3;
  localparam logic [2:0] S_RDB    = 3'd4;
  localparam logic [2:0] S_INTERP = 3'd5;
  localparam logic [2:0] S_OUT    = 3'd6;

  logic [2:0]               state;
  logic [ADDR_W-1:0]        clr_addr;
  logic [ADDR_W-1:0]        wr_ptr;
  logic signed [DATA_W-1:0] in_lat;
  logic signed [WAVE_W-1:0] wave_reg;
  logic [ADDR_W-1:0]        d_int;
  logic [FRAC_W-1:0]        frac;
  logic signed [DATA_W-1:0] tap_a;
  logic signed [DATA_W-1:0] sample_q;
  logic                     drop_q;

  // Delay RAM, no reset: the CLEAR pass zeroes it after every reset.
  logic signed [DATA_W-1:0] mem [DEPTH];
  logic signed [DATA_W-1:0] rd_data;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_waddr;
  logic signed [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0]        addr_a;
  logic [ADDR_W-1:0]        rd_addr;

  logic signed [DW-1:0]     wave_fx;
  logic signed [DW-1:0]     delay_raw;
  logic [UW-1:0]            delay_clamped;

  logic signed [DATA_W:0]   diff;
  logic signed [PW-1:0]     diff_ext;
  logic signed [PW-1:0]     frac_ext;
  logic signed [PW-1:0]     prod;
  logic signed [DATA_W-1:0] y;

  // LFO value is captured on every strobe, whatever the FSM is doing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wave_reg <= '0;
    end else if (io.newValFlag_i) begin
      wave_reg <= io.wave_i;
    end
  end

  // Fractional delay = base + scaled LFO, clamped so both taps stay inside
  // the buffer and never alias onto the sample being written.
  always_comb begin
    wave_fx   = {{(DW-WAVE_W){wave_reg[WAVE_W-1]}}, wave_reg} <<< WAVE_SHIFT;
    delay_raw = BASE_FX + wave_fx;
    if (delay_raw < MIN_FX) begin
      delay_clamped = UW'(MIN_FX);
    end else if (delay_raw > MAX_FX) begin
      delay_clamped = UW'(MAX_FX);
    end else begin
      delay_clamped = UW'(delay_raw);
    end
  end

  // Write-port steering: the clear sweep writes zeros, a pass writes the sample.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_ptr;
    mem_wdata = in_lat;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (state == S_WRITE) begin
      mem_we    = 1'b1;
    end
  end

  // Tap A is delay d_int, tap B one sample older. Both wrap modulo DEPTH.
  always_comb begin
    addr_a  = wr_ptr - d_int;
    rd_addr = (state == S_RDB) ? (addr_a - ADDR_W'(1)) : addr_a;
  end

  // Single-port synchronous RAM with one cycle of read latency.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_data <= mem[rd_addr];
  end

  // Linear interpolation a + floor((b-a)*frac / 2^FRAC_W). The result is
  // bounded by a and b, so truncation to DATA_W is lossless.
  always_comb begin
    diff     = {rd_data[DATA_W-1], rd_data} - {tap_a[DATA_W-1], tap_a};
    diff_ext = {{(PW-DATA_W-1){diff[DATA_W]}}, diff};
    frac_ext = {{(PW-FRAC_W){1'b0}}, frac};
    prod     = diff_ext * frac_ext;
    y        = tap_a + DATA_W'(prod >>> FRAC_W);
  end

  // Main sequencer: clear sweep, then one six-cycle pass per accepted sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
      wr_ptr   <= '0;
      in_lat   <= '0;
      d_int    <= '0;
      frac     <= '0;
      tap_a    <= '0;
      sample_q <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (io.sampleValid_i) begin
            in_lat <= io.sample_i;
            state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          d_int <= delay_clamped[UW-1:FRAC_W];
          frac  <= delay_clamped[FRAC_W-1:0];
          state <= S_RDA;
        end
        S_RDA: begin
          state <= S_RDB;
        end
        S_RDB: begin
          tap_a <= rd_data;
          state <= S_INTERP;
        end
        S_INTERP: begin
          sample_q <= y;
          state    <= S_OUT;
        end
        S_OUT: begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          state  <= S_IDLE;
        end
        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

  // Sticky overrun flag: any input strobe outside IDLE is lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_q <= 1'b0;
    end else if (io.sampleValid_i && (state != S_IDLE)) begin
      drop_q <= 1'b1;
    end
  end

  assign io.sample_o      = sample_q;
  assign io.sampleValid_o = (state == S_OUT);
  assign io.busy_o        = (state != S_IDLE);
  assign io.drop_o        = drop_q;
  assign dbg_state_o      = state;

endmodule

// File: tb/tb_mod_delay_reader.sv
// Directed bench for mod_delay_reader: clear timing, integer and half-sample
// delays, clamping at both ends, wrap-around ramp, overrun and mid-pass reset.
module tb_mod_delay_reader;

  localparam int DATA_W = 16;
  localparam int NDEP   = 2048;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_delay_reader_if #(.DATA_W(DATA_W)) m_if ();
  mod_delay_reader_if #(.DATA_W(DATA_W)) lo_if ();
  mod_delay_reader_if #(.DATA_W(DATA_W)) hi_if ();
  logic [2:0] m_state, lo_state, hi_state;

  mod_delay_reader #(.DATA_W(DATA_W)) u_main (
    .clk_i(clk), .rst_i(rst), .io(m_if), .dbg_state_o(m_state)
  );
  mod_delay_reader #(.DATA_W(DATA_W), .BASE_DELAY(10)) u_lo (
    .clk_i(clk), .rst_i(rst), .io(lo_if), .dbg_state_o(lo_state)
  );
  mod_delay_reader #(.DATA_W(DATA_W), .BASE_DELAY(2040)) u_hi (
    .clk_i(clk), .rst_i(rst), .io(hi_if), .dbg_state_o(hi_state)
  );

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] lo_q[$];
  logic [DATA_W-1:0] hi_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always @(negedge clk) begin
    if (m_if.sampleValid_o)  got_q.push_back(m_if.sample_o);
    if (lo_if.sampleValid_o) lo_q.push_back(lo_if.sample_o);
    if (hi_if.sampleValid_o) hi_q.push_back(hi_if.sample_o);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] q_at(input int which, input int i);
    logic [DATA_W-1:0] v;
    v = 'x;
    case (which)
      0: if (i < got_q.size()) v = got_q[i];
      1: if (i < lo_q.size())  v = lo_q[i];
      default: if (i < hi_q.size()) v = hi_q[i];
    endcase
    return v;
  endfunction

  task automatic compare_main(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), q_at(0, i), exp_q[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_valid(input bit v, input logic [DATA_W-1:0] s);
    m_if.sampleValid_i  = v;  m_if.sample_i  = s;
    lo_if.sampleValid_i = v;  lo_if.sample_i = s;
    hi_if.sampleValid_i = v;  hi_if.sample_i = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got_q.delete(); lo_q.delete(); hi_q.delete(); exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sample_o"}, m_if.sample_o, 0);
    check({tag, "_valid_o"},  m_if.sampleValid_o, 0);
    check({tag, "_busy_o"},   m_if.busy_o, 1);
    check({tag, "_drop_o"},   m_if.drop_o, 0);
  endtask

  // Counts cycles of busy after reset; optionally strobes sampleValid_i mid-clear.
  task automatic wait_clear(input string tag, input bit strobe_mid);
    int cycles;
    cycles = 0;
    while (m_if.busy_o && cycles < 3000) begin
      set_valid(strobe_mid && cycles == 100, '0);
      @(negedge clk);
      cycles++;
    end
    set_valid(1'b0, '0);
    check({tag, "_clear_cycles"}, cycles, NDEP);
  endtask

  // One sample at 6-cycle spacing, optionally with a coincident wave strobe.
  task automatic send(input logic [DATA_W-1:0] s, input bit nv, input logic [13:0] w,
                      input bit chk_lat);
    set_valid(1'b1, s);
    if (nv) begin
      m_if.wave_i = w;
      m_if.newValFlag_i = 1'b1;
    end
    @(negedge clk);
    set_valid(1'b0, '0);
    m_if.newValFlag_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (chk_lat) check($sformatf("lat_c%0d", k), m_if.sampleValid_o, (k == 5));
      @(negedge clk);
    end
    if (chk_lat) check("idle_after_pass", m_if.busy_o, 0);
  endtask

  task automatic impulse_run(input logic [DATA_W-1:0] amp, input int n, input bit nv,
                             input logic [13:0] w);
    for (int i = 0; i < n; i++) begin
      send((i == 0) ? amp : '0, nv && (i == 0), w, i < 2);
    end
  endtask

  // ---------------- main sequence ----------------
  int base_n;
  initial begin
    set_valid(1'b0, '0);
    m_if.wave_i = '0;  m_if.newValFlag_i = 1'b0;
    lo_if.wave_i = '0; lo_if.newValFlag_i = 1'b0;
    hi_if.wave_i = '0; hi_if.newValFlag_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("rst0");

    // Clear with a strobe in the middle: dropped and flagged.
    wait_clear("clr_strobe", 1'b1);
    check("drop_during_clear", m_if.drop_o, 1);

    // Fresh reset clears the sticky flag and restarts the sweep.
    do_reset();
    check_reset_vals("rst1");
    wait_clear("clr_plain", 1'b0);
    check("drop_after_reset", m_if.drop_o, 0);

    // Integer delay on main; clamp extremes on the two side instances.
    lo_if.wave_i = 14'h2000;  lo_if.newValFlag_i = 1'b1;   // -8192
    hi_if.wave_i = 14'h1FFF;  hi_if.newValFlag_i = 1'b1;   // +8191
    @(negedge clk);
    lo_if.newValFlag_i = 1'b0;
    hi_if.newValFlag_i = 1'b0;
    impulse_run(16'd1000, NDEP, 1'b0, '0);
    for (int i = 0; i < NDEP; i++) exp_q.push_back((i == 882) ? 16'd1000 : 16'd0);
    compare_main("int");
    check("lo_count", lo_q.size(), NDEP);
    check("lo[0]", q_at(1, 0), 0);
    check("lo[1]", q_at(1, 1), 1000);
    check("lo[2]", q_at(1, 2), 0);
    check("hi_count", hi_q.size(), NDEP);
    check("hi[2045]", q_at(2, 2045), 0);
    check("hi[2046]", q_at(2, 2046), 1000);
    check("hi[2047]", q_at(2, 2047), 0);

    // Half-sample delay, wave strobe coincident with the first sample.
    do_reset();
    wait_clear("clr_half_p", 1'b0);
    impulse_run(16'd1000, 886, 1'b1, 14'd32);
    for (int i = 0; i < 886; i++)
      exp_q.push_back((i == 882 || i == 883) ? 16'd500 : 16'd0);
    compare_main("half_p");

    do_reset();
    wait_clear("clr_half_n", 1'b0);
    impulse_run(16'hFC18, 886, 1'b1, 14'd32);               // -1000
    for (int i = 0; i < 886; i++)
      exp_q.push_back((i == 882 || i == 883) ? 16'hFE0C : 16'd0);   // -500
    compare_main("half_n");

    // Overrun: second strobe 3 cycles after the first is lost.
    check("drop_before_overrun", m_if.drop_o, 0);
    base_n = got_q.size();
    set_valid(1'b1, 16'd7);
    @(negedge clk);
    set_valid(1'b0, '0);
    repeat (2) @(negedge clk);
    set_valid(1'b1, 16'd9);
    @(negedge clk);
    set_valid(1'b0, '0);
    check("drop_set", m_if.drop_o, 1);
    repeat (10) @(negedge clk);
    check("drop_sticky", m_if.drop_o, 1);
    check("overrun_outputs", got_q.size() - base_n, 1);

    // Ramp across several write-pointer wraps.
    do_reset();
    wait_clear("clr_ramp", 1'b0);
    for (int i = 0; i < 5000; i++) send(16'(i), 1'b0, '0, 1'b0);
    for (int i = 0; i < 5000; i++) exp_q.push_back((i < 882) ? 16'd0 : 16'(i - 882));
    compare_main("ramp");

    // Reset mid-pass aborts the output strobe and zeroes outputs.
    base_n = got_q.size();
    set_valid(1'b1, 16'd123);
    @(negedge clk);
    set_valid(1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("rst_mid");
    repeat (8) @(negedge clk);
    check("abort_no_output", got_q.size() - base_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_delay_reader.md
# mod_delay_reader

LFO-modulated fractional delay line: the consumer of the LFO generator's `wave`/`newValFlag` stream. It buffers incoming audio samples in a circular RAM. For each sample it computes a fractional read delay of base delay plus scaled LFO value, reads two adjacent taps and linearly interpolates. The result is the delayed voice for the chorus/flanger path, sitting between the audio input FIFO and the output mixer.

## Interface
Parameters:
- `DATA_W`, default 16: audio sample width, signed.
- `ADDR_W`, default 11: delay RAM address width; DEPTH = 2^ADDR_W = 2048 samples.
- `FRAC_W`, default 8: fractional delay bits.
- `BASE_DELAY`, default 882: centre delay in samples (20 ms at 44.1 kHz).
- `WAVE_SHIFT`, default 2: left shift applied to `wave_i` before adding to the delay.

Ports:
- `clk_i`, in, 1: system clock. One clock domain.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `sample_i`, in, DATA_W signed: input audio sample.
- `sampleValid_i`, in, 1: one-cycle strobe marking a new `sample_i`.
- `wave_i`, in, 14 signed: LFO value, full scale ±8191.
- `newValFlag_i`, in, 1: one-cycle strobe marking a new `wave_i`.
- `sample_o`, out, DATA_W signed: delayed, interpolated sample.
- `sampleValid_o`, out, 1: one-cycle strobe when `sample_o` updates.
- `busy_o`, out, 1: high whenever the FSM is not in IDLE.
- `drop_o`, out, 1: sticky flag, set when a `sampleValid_i` is ignored; cleared only by reset.

## Operation
- Reset values: `sample_o`=0, `sampleValid_o`=0, `busy_o`=1, `drop_o`=0, wrPtr=0, waveReg=0, FSM in CLEAR with clrAddr=0.
- waveReg loads `wave_i` on any cycle with `newValFlag_i`=1, in any state.
- CLEAR: writes 0 to RAM[clrAddr] and increments clrAddr each cycle. After address DEPTH-1 is written, the FSM goes to IDLE, taking DEPTH cycles in total.
- IDLE: on `sampleValid_i`, latches `sample_i` and goes to WRITE.
- WRITE:
  - Writes the latched sample to RAM[wrPtr].
  - Computes delayFx = (BASE_DELAY << FRAC_W) + (sext(waveReg) <<< WAVE_SHIFT), signed, ADDR_W+FRAC_W+2 bits.
  - Clamps delayFx to [1<<FRAC_W, (DEPTH-2)<<FRAC_W].
  - Registers dInt = delayFx[ADDR_W+FRAC_W-1:FRAC_W] and frac = delayFx[FRAC_W-1:0].
- RDA: issues read of addrA = wrPtr - dInt (mod DEPTH), which is delay dInt.
- RDB: issues read of addrB = addrA - 1 (mod DEPTH), which is delay dInt+1, and captures tap a. RAM read is synchronous with 1-cycle latency.
- INTERP:
  - Captures tap b.
  - y = a + (((b - a) * frac) >>> FRAC_W).
  - b - a is DATA_W+1 bits and the product is DATA_W+FRAC_W+2 bits. The shift is arithmetic (floor).
  - y always lies within [min(a,b), max(a,b)], so no saturation is required; it is truncated to DATA_W.
- OUT: registers `sample_o`=y, pulses `sampleValid_o`, increments wrPtr modulo DEPTH (wraps 2047 -> 0), then returns to IDLE.
- Delay semantics: the sample written this pass has delay 0. With delay d = dInt + frac/2^FRAC_W, out[n] = x[n-dInt] + frac·(x[n-dInt-1] - x[n-dInt]) / 2^FRAC_W.
- Default range: the LFO contributes ±8191·4/256 ≈ ±128 samples around 882.

## Timing
- Fixed latency: `sampleValid_i` sampled in IDLE at cycle 0 gives `sampleValid_o`=1 during cycle 5 (WRITE=1, RDA=2, RDB=3, INTERP=4, OUT=5). The FSM is in IDLE again at cycle 6.
- Minimum sample spacing is 6 cycles. `sampleValid_i` in any non-IDLE state, including CLEAR, is ignored and sets `drop_o`.
- If `newValFlag_i` and `sampleValid_i` are high in the same cycle, the new wave value is used for that sample, because waveReg is read in WRITE.
- If `newValFlag_i` arrives during cycles 1–5, the delay for the current sample is already frozen; the new value applies to the next sample.
- `rst_i` mid-operation aborts the current pass with no `sampleValid_o`, restarts CLEAR and zeroes all outputs per the reset values.
- `sample_o` holds its value between strobes.

## Test plan
- Reset clear: assert `rst_i` 1 cycle -> `busy_o` high for exactly 2048 cycles. A strobe during CLEAR sets `drop_o`=1. The first 882 outputs afterwards are 0.
- Integer delay: `wave_i`=0, impulse `sample_i`=1000 followed by zeros at 6-cycle spacing -> output index 882 = 1000, all others 0. `sampleValid_o` appears 5 cycles after each input strobe.
- Half-sample delay: `wave_i`=32 (+128/256) with the same impulse -> outputs 882 and 883 both = 500, all others 0. With `sample_i`=-1000, both = -500.
- Clamp: override BASE_DELAY=10 and set `wave_i`=-8192, so delayFx < 256 -> impulse appears at output index 1. Override BASE_DELAY=2040 and set `wave_i`=+8191 -> impulse appears at index 2046.
- Wrap-around: stream a ramp 0,1,2,… for 5000 samples with `wave_i`=0 -> out[n] = n-882 for all n ≥ 882, continuous across the wrPtr 2047->0 transitions.
- Overrun/simultaneity: `sampleValid_i` 3 cycles after a prior strobe -> it is ignored, `drop_o`=1 and stays set. `newValFlag_i` coincident with `sampleValid_i` carrying `wave_i`=32 -> that sample uses delay 882.5.
